// File: rtl/if_prefetch.sv
// Generic flushable FIFO with a registered occupancy count and a zeroed head when empty.
// Latency: a push is visible at the head on the following cycle; there is no bypass.
// Backpressure: the owner must not push when full unless it pops in the same cycle.
module if_prefetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [W-1:0]     push_dat_i,
    input  logic             pop_i,
    output logic             head_vld_o,
    output logic [W-1:0]     head_dat_o,
    output logic [PTR_W:0]   count_o
);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push_i && !pop_i)      count_d = count_q + CNT_ONE;
            else if (!push_i && pop_i) count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the count is zero.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_vld_o = (count_q != '0);
    assign head_dat_o = head_vld_o ? mem_q[rd_ptr_q] : '0;
    assign count_o    = count_q;
endmodule

// Instruction fetch stage: drives the ROM from the fetch PC and queues {addr, inst} for decode.
// Latency: a word fetched in cycle N reaches the head in cycle N+1; a jump target in cycle J+2.
// Backpressure: fetch stalls when the queue is full unless decode pops in the same cycle.
module if_prefetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter int          PTR_W    = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic             rom_ce_o,
    output logic [31:0]      rom_addr_o,
    input  logic [31:0]      rom_inst_i,
    input  logic             jump_i,
    input  logic [31:0]      jump_addr_i,
    output logic             inst_valid_o,
    output logic [31:0]      inst_o,
    output logic [31:0]      inst_addr_o,
    input  logic             inst_ready_i,
    output logic [PTR_W:0]   count_o
);
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
    } entry_t;

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [31:0]    fpc_q, fpc_d;
    logic           pop, fetch;
    logic           head_vld;
    entry_t         push_dat, head_dat;
    logic [PTR_W:0] count;
    logic           unused_jump_lsbs;

    assign unused_jump_lsbs = ^jump_addr_i[1:0];

    assign pop   = head_vld & inst_ready_i;
    assign fetch = ~rst & ~jump_i & ((count < DEPTH_C) | pop);

    always_comb begin
        fpc_d = fpc_q;
        if (jump_i)     fpc_d = {jump_addr_i[31:2], 2'b00};
        else if (fetch) fpc_d = fpc_q + 32'd4;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fpc_q <= {RESET_PC[31:2], 2'b00};
        else     fpc_q <= fpc_d;
    end

    assign push_dat.addr = fpc_q;
    assign push_dat.inst = rom_inst_i;

    // A jump flushes the queue and swallows any pop decode attempted that cycle.
    if_prefetch_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (jump_i),
        .push_i     (fetch),
        .push_dat_i (push_dat),
        .pop_i      (pop & ~jump_i),
        .head_vld_o (head_vld),
        .head_dat_o (head_dat),
        .count_o    (count)
    );

    assign rom_ce_o     = fetch;
    assign rom_addr_o   = fpc_q;
    assign inst_valid_o = head_vld;
    assign inst_o       = head_dat.inst;
    assign inst_addr_o  = head_dat.addr;
    assign count_o      = count;
endmodule

// File: doc/if_prefetch.md
Name: if_prefetch

Overview:
- Instruction fetch stage that sits directly upstream of the instruction ROM.
- Owns the fetch PC and drives the ROM read enable and address.
- Captures each returned instruction word, with its address, into a small FIFO.
- Presents queued instructions to the decode stage over a valid/ready handshake.
- A jump/redirect from execute flushes the queue and restarts fetch at the new target.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- DEPTH, 4, queue entries; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rom_ce_o  out  1  ROM read enable; 1 = read.
- rom_addr_o  out  32  ROM byte address; bits [1:0] always 0.
- rom_inst_i  in  32  ROM read data; combinational, valid in the same cycle as rom_addr_o.
- jump_i  in  1  redirect request from execute.
- jump_addr_i  in  32  redirect target.
- inst_valid_o  out  1  queue head is valid.
- inst_o  out  32  queue head instruction.
- inst_addr_o  out  32  byte address of the queue head.
- inst_ready_i  in  1  decode accepts the head this cycle.
- count_o  out  PTR_W+1  current queue occupancy, 0..DEPTH.

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - fpc = RESET_PC; rd_ptr = wr_ptr = 0; count = 0.
  - inst_valid_o = 0; count_o = 0.
  - inst_o = 32'h0 and inst_addr_o = 32'h0 while empty.
  - rom_ce_o = 0 while rst is high.
- Pop: pop = inst_valid_o & inst_ready_i.
- Fetch condition: fetch = ~rst & ~jump_i & (count < DEPTH | pop).
  - This is combinational: rom_ce_o depends on inst_ready_i in the full case.
- ROM outputs:
  - rom_ce_o = fetch.
  - rom_addr_o = fpc at all times, with bits [1:0] = 0.
- On a fetch edge:
  - Write {fpc, rom_inst_i} to entry wr_ptr.
  - wr_ptr increments, wrapping mod DEPTH.
  - fpc = fpc + 4, wrapping mod 2^32; 32'hFFFF_FFFC is followed by 32'h0.
- Head outputs:
  - inst_valid_o = (count != 0).
  - inst_o and inst_addr_o come from entry rd_ptr and are held stable until popped.
  - inst_o reads 32'h0 when empty.
- Fetch-to-decode latency: an instruction fetched in cycle N is visible at the head in cycle N+1 when the queue was empty. There is no bypass.
- Count update:
  - count+1 on fetch without pop.
  - count-1 on pop without fetch.
  - unchanged on fetch with pop, including the full case: the pop frees a slot and the fetch refills it in the same edge.
- Jump (highest priority):
  - When jump_i = 1, at the edge: count = 0, rd_ptr = wr_ptr = 0, fpc = {jump_addr_i[31:2], 2'b00}.
  - No push and no ROM read that cycle.
  - A concurrent pop is discarded; decode must also ignore the head that cycle.
  - Fetching from the target starts the next cycle, and the target instruction is valid 2 cycles after the jump cycle.
  - Back-to-back jumps: the last one wins.
- Handshake rules:
  - inst_valid_o never depends combinationally on inst_ready_i.
  - The head does not change while inst_valid_o = 1 and inst_ready_i = 0.
- Reset asserted mid-operation: all queued entries are discarded immediately and fetch restarts at RESET_PC after release.

Test Plan:
- Reset release, inst_ready_i = 1, ROM word i = 32'h1000_0000 + i: inst_valid_o first rises 1 cycle after release with inst_addr_o = 0, inst_o = 32'h1000_0000; addresses then follow 0, 4, 8… one per cycle with no bubbles.
- inst_ready_i = 0 from reset: count_o reaches 4 after 4 fetches, then rom_ce_o = 0 and the head is held at addr 0. Raising inst_ready_i for 1 cycle pops addr 0 and pushes addr 16 in the same edge; count_o stays 4.
- Jump with jump_addr_i = 32'h0000_0103 while count = 3: queue empties, inst_valid_o = 0 for the next cycle, then the head shows addr 32'h100. No stale entry (pre-jump address) is ever presented.
- Jump and pop in the same cycle, followed by a second jump to 32'h200 the next cycle: only the 32'h200 stream appears, with rom_ce_o = 0 in both jump cycles.
- RESET_PC = 32'hFFFF_FFF8, ready = 1: head addresses are FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- rst pulsed while count = 2: count_o = 0 and inst_valid_o = 0 asynchronously, before the next clock edge; after release fetch resumes at RESET_PC.
